irfft_ctrl: RTL and testbench

- Control sequencer for the inverse real FFT. It is the other direction of the forward rfft sequencer.
- It walks the radix-2 stages in reverse order (LOG2N-1 down to 0, decimation-in-frequency) and issues one butterfly per handshake.
- Each butterfly carries its operand addresses and a conjugated twiddle index, and the block tracks in-flight butterflies to the datapath.
- It pulses done after the last butterfly of stage 0 has retired. It sits between the host start logic and the shared butterfly/memory datapath.

---
 rtl/fft_pkg.sv | 38 +++
 rtl/irfft_ctrl_if.sv | 25 ++
 rtl/irfft_addr_gen.sv | 22 ++
 rtl/irfft_ctrl.sv | 119 +++++++++++
 tb/tb_irfft_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT sequencer definitions: state encoding, size constants and the
// radix-2 butterfly address function used by both transform directions.
package fft_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fft_state_e;

    localparam int LOG2N_DEF  = 7;
    localparam int HALF_N_DEF = 1 << (LOG2N_DEF - 1);

    typedef struct packed {
        logic [31:0] addr_a;
        logic [31:0] addr_b;
        logic [31:0] tw_idx;
    } bf_addr_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Butterfly k of a stage pairs elements that differ only in bit 'stage'.
    function automatic bf_addr_t bf_addr(input int log2n, input int stage, input int bf_idx);
        int       span;
        int       pos;
        int       grp;
        bf_addr_t r;
        span     = 1 << stage;
        pos      = bf_idx & (span - 1);
        grp      = bf_idx >> stage;
        r.addr_a = (grp << (stage + 1)) | pos;
        r.addr_b = r.addr_a + span;
        r.tw_idx = pos << (log2n - 1 - stage);
        return r;
    endfunction

endpackage

// File: rtl/irfft_ctrl_if.sv
// Butterfly request/retire bus between the sequencer and the shared datapath.
interface irfft_ctrl_if #(
    parameter int LOG2N = 7,
    parameter int SW    = 4
);
    logic             bf_valid;
    logic             bf_ready;
    logic [SW-1:0]    stage;
    logic [LOG2N-2:0] bf_idx;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic             tw_conj;
    logic             bf_wb;

    modport master (
        output bf_valid, stage, bf_idx, addr_a, addr_b, tw_idx, tw_conj,
        input  bf_ready, bf_wb
    );

    modport slave (
        input  bf_valid, stage, bf_idx, addr_a, addr_b, tw_idx, tw_conj,
        output bf_ready, bf_wb
    );
endinterface

// File: rtl/irfft_addr_gen.sv
// Combinational operand/twiddle address generator for one radix-2 butterfly.
module irfft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int SW    = 4
) (
    input  logic [SW-1:0]    stage_i,
    input  logic [LOG2N-2:0] bf_idx_i,
    output logic [LOG2N-1:0] addr_a_o,
    output logic [LOG2N-1:0] addr_b_o,
    output logic [LOG2N-2:0] tw_idx_o
);
    bf_addr_t addr;

    always_comb begin
        addr     = bf_addr(LOG2N, int'(stage_i), int'(bf_idx_i));
        addr_a_o = addr.addr_a[LOG2N-1:0];
        addr_b_o = addr.addr_b[LOG2N-1:0];
        tw_idx_o = addr.tw_idx[LOG2N-2:0];
    end
endmodule

// File: rtl/irfft_ctrl.sv
// Inverse real FFT sequencer: walks stages LOG2N-1 down to 0, issues one
// butterfly per handshake and drains all in-flight work between stages.
module irfft_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N        = LOG2N_DEF,
    parameter int MAX_INFLIGHT = 8,
    parameter int SW           = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         start_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_underflow_o,
    irfft_ctrl_if.master bf
);
    localparam int               IW        = clog2(MAX_INFLIGHT + 1);
    localparam logic [SW-1:0]    TOP_STAGE = SW'(LOG2N - 1);
    localparam logic [IW-1:0]    MAX_CNT   = IW'(MAX_INFLIGHT);

    fft_state_e       state_q, state_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [LOG2N-2:0] bf_idx_q, bf_idx_d;
    logic [IW-1:0]    inflight_q, inflight_d;
    logic             err_q, err_d;
    logic             handshake;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            stage_q    <= '0;
            bf_idx_q   <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            bf_idx_q   <= bf_idx_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // NOTE: every combinational output is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        bf_idx_d = bf_idx_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = ISSUE;
                    stage_d  = TOP_STAGE;
                    bf_idx_d = '0;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    bf_idx_d = bf_idx_q + 1'b1;
                    if (bf_idx_q == '1) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Stage s-1 reads stage s results, so wait for every retire.
                if (inflight_d == '0) begin
                    if (stage_q == '0) begin
                        state_d = DONE;
                    end else begin
                        stage_d = stage_q - 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        err_d      = err_q;
        if (bf.bf_wb && (inflight_q == '0)) begin
            // A retire with nothing outstanding is discarded and flagged.
            err_d = 1'b1;
            if (handshake) inflight_d = inflight_q + 1'b1;
        end else if (handshake && !bf.bf_wb) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!handshake && bf.bf_wb) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_comb begin
        bf.bf_valid     = (state_q == ISSUE) && (inflight_q < MAX_CNT);
        busy_o          = (state_q != IDLE);
        done_o          = (state_q == DONE);
        err_underflow_o = err_q;
        bf.stage        = stage_q;
        bf.bf_idx       = bf_idx_q;
        bf.tw_conj      = 1'b1;
    end

    assign handshake = bf.bf_valid && bf.bf_ready;

    irfft_addr_gen #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_addr_gen (
        .stage_i  (stage_q),
        .bf_idx_i (bf_idx_q),
        .addr_a_o (bf.addr_a),
        .addr_b_o (bf.addr_b),
        .tw_idx_o (bf.tw_idx)
    );
endmodule

// File: tb/tb_irfft_ctrl.sv
// Directed bench for irfft_ctrl: reset, full runs, backpressure, start
// filtering, underflow flag and mid-run reset.
module tb_irfft_ctrl;
    import fft_pkg::*;

    localparam int LOG2N        = 7;
    localparam int MAX_INFLIGHT = 8;
    localparam int SW           = 4;

    logic Clk = 1'b0;
    logic Reset;
    logic start_i;
    logic busy_o;
    logic done_o;
    logic err_underflow_o;

    int n_cmp = 0;
    int n_bad = 0;

    irfft_ctrl_if #(.LOG2N(LOG2N), .SW(SW)) bf_if ();

    irfft_ctrl #(
        .LOG2N        (LOG2N),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .SW           (SW)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .start_i         (start_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_underflow_o (err_underflow_o),
        .bf              (bf_if)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference addresses: butterfly k uses the k-th address whose bit s is
    // clear, its partner is span above, twiddle scales the in-group offset.
    function automatic void model_addr(input int s, input int k,
                                       output int a, output int b, output int tw);
        int seen;
        seen = 0;
        a    = -1;
        for (int x = 0; x < 128; x++) begin
            if (((x / (1 << s)) % 2) == 0) begin
                if (seen == k && a < 0) a = x;
                seen++;
            end
        end
        b  = a + (1 << s);
        tw = (a % (1 << s)) * (64 / (1 << s));
    endfunction

    task automatic apply_reset();
        Reset          = 1'b1;
        start_i        = 1'b0;
        bf_if.bf_ready = 1'b0;
        bf_if.bf_wb    = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({busy_o, done_o, err_underflow_o, bf_if.bf_valid} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got busy/done/err/valid=%b required 0000",
                     {busy_o, done_o, err_underflow_o, bf_if.bf_valid});
        end
        n_cmp++;
        if (bf_if.stage !== 4'd0 || bf_if.bf_idx !== 6'd0) begin
            n_bad++;
            $display("FAIL reset_regs: got stage=%0d bf_idx=%0d required 0/0",
                     bf_if.stage, bf_if.bf_idx);
        end
    endtask

    task automatic run_transform(input bit rand_ready, input bit poke_start, input string tag);
        int               exp_stage, exp_idx, hs_total, tb_out, cycles, last_stage, extra_done;
        int               ma, mb, mt;
        bit [2:0]         pipe;
        bit               hs, prev_stall;
        logic [LOG2N-1:0] hold_a, hold_b;
        logic [LOG2N-2:0] hold_idx;
        logic [SW-1:0]    hold_stage;

        start_i        = 1'b1;
        bf_if.bf_ready = 1'b1;
        bf_if.bf_wb    = 1'b0;
        tick();
        start_i = 1'b0;
        n_cmp++;
        if (bf_if.bf_valid !== 1'b1 || bf_if.stage !== 4'd6 || bf_if.bf_idx !== 6'd0) begin
            n_bad++;
            $display("FAIL %s_first_issue: got valid=%b stage=%0d idx=%0d required 1/6/0",
                     tag, bf_if.bf_valid, bf_if.stage, bf_if.bf_idx);
        end

        exp_stage  = 6;
        exp_idx    = 0;
        hs_total   = 0;
        tb_out     = 0;
        cycles     = 0;
        last_stage = 6;
        pipe       = '0;
        prev_stall = 1'b0;
        hold_a     = '0;
        hold_b     = '0;
        hold_idx   = '0;
        hold_stage = '0;

        while (cycles < 3000) begin
            if (done_o) break;
            if (prev_stall) begin
                n_cmp++;
                if (bf_if.bf_valid !== 1'b1 || bf_if.addr_a !== hold_a || bf_if.addr_b !== hold_b ||
                    bf_if.bf_idx !== hold_idx || bf_if.stage !== hold_stage) begin
                    n_bad++;
                    $display("FAIL %s_stall_hold: got v=%b a=%0d b=%0d idx=%0d required 1/%0d/%0d/%0d",
                             tag, bf_if.bf_valid, bf_if.addr_a, bf_if.addr_b, bf_if.bf_idx,
                             hold_a, hold_b, hold_idx);
                end
            end
            bf_if.bf_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bf_if.bf_wb    = pipe[2];
            start_i = poke_start && ((busy_o && !bf_if.bf_valid) ||
                                     (bf_if.bf_valid && bf_if.bf_idx == 6'd20));
            hs = bf_if.bf_valid && bf_if.bf_ready;

            if (hs) begin
                n_cmp++;
                if (int'(bf_if.stage) !== exp_stage || int'(bf_if.bf_idx) !== exp_idx) begin
                    n_bad++;
                    $display("FAIL %s_sequence: got stage=%0d idx=%0d required %0d/%0d",
                             tag, bf_if.stage, bf_if.bf_idx, exp_stage, exp_idx);
                end
                model_addr(exp_stage, exp_idx, ma, mb, mt);
                n_cmp++;
                if (int'(bf_if.addr_a) !== ma || int'(bf_if.addr_b) !== mb ||
                    int'(bf_if.tw_idx) !== mt) begin
                    n_bad++;
                    $display("FAIL %s_addr s%0d k%0d: got a=%0d b=%0d tw=%0d required %0d/%0d/%0d",
                             tag, exp_stage, exp_idx, bf_if.addr_a, bf_if.addr_b, bf_if.tw_idx,
                             ma, mb, mt);
                end
                if ((exp_stage == 6 && exp_idx == 5) || (exp_stage == 3 && exp_idx == 13) ||
                    (exp_stage == 0 && exp_idx == 5)) begin
                    n_cmp++;
                    if (!((exp_stage == 6 && bf_if.addr_a == 7'd5  && bf_if.addr_b == 7'd69 && bf_if.tw_idx == 6'd5)  ||
                          (exp_stage == 3 && bf_if.addr_a == 7'd21 && bf_if.addr_b == 7'd29 && bf_if.tw_idx == 6'd40) ||
                          (exp_stage == 0 && bf_if.addr_a == 7'd10 && bf_if.addr_b == 7'd11 && bf_if.tw_idx == 6'd0))) begin
                        n_bad++;
                        $display("FAIL %s_addr_vector s%0d k%0d: got a=%0d b=%0d tw=%0d",
                                 tag, exp_stage, exp_idx, bf_if.addr_a, bf_if.addr_b, bf_if.tw_idx);
                    end
                end
                if (hs_total == 0) begin
                    n_cmp++;
                    if (bf_if.tw_conj !== 1'b1) begin
                        n_bad++;
                        $display("FAIL %s_tw_conj: got %b required 1", tag, bf_if.tw_conj);
                    end
                end
                if (int'(bf_if.stage) != last_stage) begin
                    n_cmp++;
                    if (tb_out !== 0) begin
                        n_bad++;
                        $display("FAIL %s_barrier stage %0d: got %0d outstanding required 0",
                                 tag, bf_if.stage, tb_out);
                    end
                    last_stage = int'(bf_if.stage);
                end
                exp_idx++;
                if (exp_idx == 64) begin
                    exp_idx = 0;
                    exp_stage--;
                end
            end

            prev_stall = bf_if.bf_valid && !bf_if.bf_ready;
            hold_a     = bf_if.addr_a;
            hold_b     = bf_if.addr_b;
            hold_idx   = bf_if.bf_idx;
            hold_stage = bf_if.stage;
            tb_out     = tb_out + int'(hs) - int'(bf_if.bf_wb);
            pipe       = {pipe[1:0], hs};
            hs_total   = hs_total + int'(hs);
            tick();
            cycles++;
        end

        n_cmp++;
        if (done_o !== 1'b1 || busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_done_reached: got done=%b busy=%b after %0d cycles required 1/1",
                     tag, done_o, busy_o, cycles);
        end
        n_cmp++;
        if (hs_total !== 448 || exp_stage !== -1) begin
            n_bad++;
            $display("FAIL %s_handshakes: got %0d (next stage %0d) required 448 (-1)",
                     tag, hs_total, exp_stage);
        end
        start_i        = 1'b0;
        bf_if.bf_ready = 1'b0;
        bf_if.bf_wb    = 1'b0;
        tick();
        n_cmp++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_done_width: got done=%b busy=%b required 0/0", tag, done_o, busy_o);
        end
        extra_done = 0;
        for (int i = 0; i < 5; i++) begin
            extra_done += int'(done_o) + int'(busy_o);
            tick();
        end
        n_cmp++;
        if (extra_done !== 0 || err_underflow_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle_after: got %0d busy/done cycles err=%b required 0/0",
                     tag, extra_done, err_underflow_o);
        end
    endtask

    task automatic test_full_run();
        run_transform(1'b0, 1'b1, "full");
    endtask

    task automatic test_random_ready();
        run_transform(1'b1, 1'b0, "rand");
    endtask

    task automatic test_backpressure();
        int hs_cnt, cycles;
        start_i        = 1'b1;
        bf_if.bf_ready = 1'b1;
        bf_if.bf_wb    = 1'b0;
        tick();
        start_i = 1'b0;
        hs_cnt  = 0;
        cycles  = 0;
        while (bf_if.bf_valid && cycles < 50) begin
            hs_cnt++;
            tick();
            cycles++;
        end
        n_cmp++;
        if (hs_cnt !== MAX_INFLIGHT) begin
            n_bad++;
            $display("FAIL bp_saturate: got %0d handshakes required %0d", hs_cnt, MAX_INFLIGHT);
        end
        tick();
        tick();
        n_cmp++;
        if (bf_if.bf_valid !== 1'b0 || busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_hold_off: got valid=%b busy=%b required 0/1", bf_if.bf_valid, busy_o);
        end
        bf_if.bf_wb = 1'b1;
        tick();
        bf_if.bf_wb = 1'b0;
        hs_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (bf_if.bf_valid) hs_cnt++;
            tick();
        end
        n_cmp++;
        if (hs_cnt !== 1) begin
            n_bad++;
            $display("FAIL bp_one_more: got %0d handshakes required 1", hs_cnt);
        end
        apply_reset();
    endtask

    task automatic test_underflow();
        int hs_cnt, cycles;
        bf_if.bf_wb = 1'b1;
        tick();
        bf_if.bf_wb = 1'b0;
        n_cmp++;
        if (err_underflow_o !== 1'b1 || busy_o !== 1'b0 || bf_if.bf_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL underflow_flag: got err=%b busy=%b valid=%b required 1/0/0",
                     err_underflow_o, busy_o, bf_if.bf_valid);
        end
        start_i        = 1'b1;
        bf_if.bf_ready = 1'b1;
        tick();
        start_i = 1'b0;
        hs_cnt  = 0;
        cycles  = 0;
        while (bf_if.bf_valid && cycles < 50) begin
            hs_cnt++;
            tick();
            cycles++;
        end
        n_cmp++;
        if (hs_cnt !== MAX_INFLIGHT || err_underflow_o !== 1'b1) begin
            n_bad++;
            $display("FAIL underflow_count: got %0d handshakes err=%b required %0d/1",
                     hs_cnt, err_underflow_o, MAX_INFLIGHT);
        end
        apply_reset();
        n_cmp++;
        if (err_underflow_o !== 1'b0) begin
            n_bad++;
            $display("FAIL underflow_clear: got err=%b required 0", err_underflow_o);
        end
    endtask

    task automatic test_reset_mid_run();
        int       cycles;
        bit [2:0] pipe;
        bit       hs;
        start_i        = 1'b1;
        bf_if.bf_ready = 1'b1;
        bf_if.bf_wb    = 1'b0;
        tick();
        start_i = 1'b0;
        pipe    = '0;
        cycles  = 0;
        while (!(bf_if.stage == 4'd4 && bf_if.bf_idx == 6'd10) && cycles < 1000) begin
            bf_if.bf_wb = pipe[2];
            hs          = bf_if.bf_valid && bf_if.bf_ready;
            pipe        = {pipe[1:0], hs};
            tick();
            cycles++;
        end
        n_cmp++;
        if (bf_if.stage !== 4'd4 || bf_if.bf_idx !== 6'd10 || busy_o !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_reach: got stage=%0d idx=%0d busy=%b required 4/10/1",
                     bf_if.stage, bf_if.bf_idx, busy_o);
        end
        Reset          = 1'b1;
        bf_if.bf_ready = 1'b0;
        bf_if.bf_wb    = 1'b0;
        tick();
        Reset = 1'b0;
        n_cmp++;
        if ({busy_o, done_o, err_underflow_o, bf_if.bf_valid} !== 4'b0000 ||
            bf_if.stage !== 4'd0 || bf_if.bf_idx !== 6'd0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got flags=%b stage=%0d idx=%0d required 0000/0/0",
                     {busy_o, done_o, err_underflow_o, bf_if.bf_valid}, bf_if.stage, bf_if.bf_idx);
        end
        bf_if.bf_wb = 1'b1;
        tick();
        bf_if.bf_wb = 1'b0;
        n_cmp++;
        if (err_underflow_o !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_stale_wb: got err=%b required 1", err_underflow_o);
        end
        start_i        = 1'b1;
        bf_if.bf_ready = 1'b1;
        tick();
        start_i = 1'b0;
        n_cmp++;
        if (bf_if.bf_valid !== 1'b1 || bf_if.stage !== 4'd6 || bf_if.bf_idx !== 6'd0) begin
            n_bad++;
            $display("FAIL midrst_restart: got valid=%b stage=%0d idx=%0d required 1/6/0",
                     bf_if.bf_valid, bf_if.stage, bf_if.bf_idx);
        end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_random_ready();
        test_backpressure();
        test_underflow();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
